vga_scroll_addr_gen: RTL

//  Parametrised successor of the frame-buffer address generator. Maps VGA counters (h_cnt, v_cnt)
//  to a pixel-memory address for a 2^SCALE_SHIFT-downscaled image, with four-way wrap-around scrolling.
//  The scroll offset updates at frame rate, so no slow divided clock is needed.

---
 rtl/vga_pkg.sv | 19 +
 rtl/mod_step.sv | 30 +++
 rtl/vga_scroll_addr_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default active-area timing, scroll mode encodings
// and image-dimension helper.
package vga_pkg;

  localparam int unsigned H_ACT_DEF = 640;
  localparam int unsigned V_ACT_DEF = 480;

  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_RIGHT = 2'b11
  } scroll_mode_e;

  function automatic int unsigned img_dim(input int unsigned act, input int unsigned shift);
    return act >> shift;
  endfunction

endpackage

// File: rtl/mod_step.sv
// Combinational modular step: res = (val + step) mod dim, or (val - step) mod dim
// when dir=1. Assumes val < dim and step < dim.
module mod_step #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] val,
  input  logic [3:0]   step,
  input  logic [W:0]   dim,
  input  logic         dir,
  output logic [W-1:0] res
);

  logic [W:0] val_x;
  logic [W:0] step_x;
  logic [W:0] sum;
  logic [W:0] res_w;

  always_comb begin
    val_x  = {1'b0, val};
    step_x = {{(W-3){1'b0}}, step};
    sum    = val_x + step_x;
    if (dir) begin
      res_w = (val_x < step_x) ? (val_x + dim - step_x) : (val_x - step_x);
    end else begin
      res_w = (sum >= dim) ? (sum - dim) : sum;
    end
    res = res_w[W-1:0];
  end

endmodule

// File: rtl/vga_scroll_addr_gen.sv
// Maps VGA counters to a downscaled frame-buffer address with wrap-around
// scrolling; offsets step once per FRAME_DIV frames at the start of v-blank.
module vga_scroll_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT       = H_ACT_DEF,
  parameter int unsigned V_ACT       = V_ACT_DEF,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned FRAME_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              home,
  input  logic [1:0]        mode,
  input  logic [3:0]        step,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              addr_valid,
  output logic [8:0]        x_off,
  output logic [8:0]        y_off
);

  localparam int unsigned IMG_W = img_dim(H_ACT, SCALE_SHIFT);
  localparam int unsigned IMG_H = img_dim(V_ACT, SCALE_SHIFT);
  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  scroll_mode_e mode_e;

  logic [9:0]        xs_q, xs_d, ys_q, ys_d;
  logic              v1_q, v1_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic [8:0]        x_off_q, x_off_d, y_off_q, y_off_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              tick_cond_q, tick_cond_d;

  logic [9:0]  xi, yi;
  logic [10:0] xsum, ysum, xwrap, ywrap;
  logic [31:0] prod, addr_sum;
  logic        tick, upd;
  logic [8:0]  x_step_res, y_step_res;

  assign mode_e = scroll_mode_e'(mode);

  mod_step #(.W(9)) u_step_x (
    .val (x_off_q),
    .step(step),
    .dim (10'(IMG_W)),
    .dir (mode_e == MODE_RIGHT),
    .res (x_step_res)
  );

  mod_step #(.W(9)) u_step_y (
    .val (y_off_q),
    .step(step),
    .dim (10'(IMG_H)),
    .dir (mode_e == MODE_DOWN),
    .res (y_step_res)
  );

  // 320 = 256 + 64, so the default row stride needs only two shifts and an add
  if (IMG_W == 320) begin : g_shift_add
    assign prod = ({22'b0, ys_q} << 8) + ({22'b0, ys_q} << 6);
  end else begin : g_mul
    assign prod = {22'b0, ys_q} * IMG_W;
  end

  always_comb begin
    xi    = h_cnt >> SCALE_SHIFT;
    yi    = v_cnt >> SCALE_SHIFT;
    xsum  = {1'b0, xi} + {2'b0, x_off_q};
    ysum  = {1'b0, yi} + {2'b0, y_off_q};
    xwrap = (xsum >= 11'(IMG_W)) ? (xsum - 11'(IMG_W)) : xsum;
    ywrap = (ysum >= 11'(IMG_H)) ? (ysum - 11'(IMG_H)) : ysum;
    xs_d  = xwrap[9:0];
    ys_d  = ywrap[9:0];
    v1_d  = valid;

    addr_sum     = prod + {22'b0, xs_q};
    pixel_addr_d = addr_sum[ADDR_W-1:0];
    addr_valid_d = v1_q;

    tick_cond_d = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACT));
    tick        = tick_cond_d && !tick_cond_q;

    fcnt_d = fcnt_q;
    upd    = 1'b0;
    if (tick && en) begin
      if (fcnt_q == CNT_W'(FRAME_DIV - 1)) begin
        fcnt_d = '0;
        upd    = 1'b1;
      end else begin
        fcnt_d = fcnt_q + CNT_W'(1);
      end
    end

    x_off_d = x_off_q;
    y_off_d = y_off_q;
    if (home) begin
      fcnt_d  = '0;
      x_off_d = '0;
      y_off_d = '0;
    end else if (upd) begin
      unique case (mode_e)
        MODE_UP, MODE_DOWN:    y_off_d = y_step_res;
        MODE_LEFT, MODE_RIGHT: x_off_d = x_step_res;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q         <= '0;
      ys_q         <= '0;
      v1_q         <= 1'b0;
      pixel_addr_q <= '0;
      addr_valid_q <= 1'b0;
      x_off_q      <= '0;
      y_off_q      <= '0;
      fcnt_q       <= '0;
      tick_cond_q  <= 1'b0;
    end else begin
      xs_q         <= xs_d;
      ys_q         <= ys_d;
      v1_q         <= v1_d;
      pixel_addr_q <= pixel_addr_d;
      addr_valid_q <= addr_valid_d;
      x_off_q      <= x_off_d;
      y_off_q      <= y_off_d;
      fcnt_q       <= fcnt_d;
      tick_cond_q  <= tick_cond_d;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign addr_valid = addr_valid_q;
  assign x_off      = x_off_q;
  assign y_off      = y_off_q;

endmodule
